vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port vga_clk, input, 1, pixel clock; the block's single clock.
REQ-010 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port DrawX, output, 10, current horizontal pixel coordinate.
REQ-012 SHALL have port DrawY, output, 10, current line coordinate.
REQ-013 SHALL have port blank, output, 1, display enable: 1 = visible pixel, 0 = blanking.
REQ-014 SHALL have port hs, output, 1, horizontal sync, active-low.
REQ-015 SHALL have port vs, output, 1, vertical sync, active-low.
REQ-016 SHALL have port line_start, output, 1, one-cycle pulse when DrawX == 0.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse when DrawX == 0 and DrawY == 0.

Function
REQ-018 SHALL keep a horizontal counter over 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default).
REQ-019 SHALL keep a vertical counter over 0..V_TOTAL-1, where V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-020 SHALL increment the horizontal counter on every vga_clk rising edge and wrap it from H_TOTAL-1 to 0.
REQ-021 SHALL increment the vertical counter only on the edge where the horizontal counter wraps, and wrap it from V_TOTAL-1 to 0 on that same edge.
REQ-022 SHALL drive every output from a flop, with no combinational path from counters to ports.
REQ-023 SHALL present hs, vs, blank, line_start and frame_start in the same cycle as the DrawX/DrawY value they describe, by decoding the next-state counter values; zero-cycle skew between the coordinate outputs and the sync/blank/pulse outputs.
REQ-024 SHALL set blank = 1 if and only if DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-025 SHALL drive hs = 0 if and only if H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-026 SHALL drive vs = 0 if and only if V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), for the whole line.
REQ-027 SHALL decode sync and blank from the horizontal and vertical phases VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE; each counter advances its phase when it reaches the phase's end count.
REQ-028 SHALL hold DrawX and DrawY at their raw counter values during blanking, not clamped or zeroed.

Reset
REQ-029 SHALL, while reset_n = 0 and independent of vga_clk, hold DrawX = H_TOTAL-1, DrawY = V_TOTAL-1, blank = 0, hs = 1, vs = 1, line_start = 0 and frame_start = 0.
REQ-030 SHALL, on the first vga_clk rising edge after reset_n is released, output DrawX = 0, DrawY = 0, blank = 1, line_start = 1 and frame_start = 1.
REQ-031 SHALL, when reset is asserted mid-frame, return all outputs to their reset values at once, and on release restart at the top of a frame with no partial sync pulse.

Structure
REQ-032 SHALL take the default timing constants, H_TOTAL/V_TOTAL derivation and the phase enum (VISIBLE, FRONT, SYNC, BACK) from a shared package vga_timing_pkg.
REQ-033 SHALL implement one sub-module, vga_axis_counter, that holds one counter plus its phase FSM and exposes wrap, sync and visible decodes, and SHALL instantiate it twice (horizontal, and vertical enabled by the horizontal wrap).

Verification
REQ-034 SHALL verify: reset held, then released -> DrawX = 799, DrawY = 524, blank = 0, hs = vs = 1 during reset; first edge gives (0,0) with frame_start = line_start = blank = 1.
REQ-035 SHALL verify: run one line -> hs low for exactly 96 consecutive cycles at DrawX 656..751; blank high for exactly 640 cycles at DrawX 0..639.
REQ-036 SHALL verify: cross the line boundary -> DrawX goes 799 -> 0 and DrawY increments on the same edge; DrawY goes 524 -> 0 together with DrawX 799 -> 0.
REQ-037 SHALL verify: run one full frame -> 420000 cycles between frame_start pulses, 307200 blank-high cycles, 525 line_start pulses, vs low for exactly 1600 cycles (lines 490..491).
REQ-038 SHALL verify: assert reset_n at DrawX = 700, DrawY = 491 (inside hs and vs) -> hs and vs go to 1 without waiting for a clock edge; after release, the next frame_start arrives on the first edge.
REQ-039 SHALL verify: instantiate with non-default parameters (H_VISIBLE = 8, H_FRONT = 2, H_SYNC = 3, H_BACK = 1, V totals similar) -> hs/vs/blank windows and the wrap points follow the formulas in REQ-024 through REQ-026.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase encoding and raster payload type.
package vga_timing_pkg;

  // Coordinate width of DrawX/DrawY; must hold H_TOTAL-1 and V_TOTAL-1.
  localparam int unsigned COORD_W = 10;

  // 640x480 @ 60 Hz defaults.
  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  typedef logic [COORD_W-1:0] coord_t;

  // Phases walked by each axis counter, in display order.
  typedef enum logic [1:0] {
    PH_VISIBLE = 2'd0,
    PH_FRONT   = 2'd1,
    PH_SYNC    = 2'd2,
    PH_BACK    = 2'd3
  } phase_e;

  // Registered raster outputs; syncs are stored active-low as driven.
  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   blank;
    logic   hs_n;
    logic   vs_n;
    logic   line_start;
    logic   frame_start;
  } raster_t;

  // Total count of one axis (visible + porches + sync).
  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync_w,
                                             input int unsigned back);
    return visible + front + sync_w + back;
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle carried from the timing generator to display consumers.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               blank;
  logic               hs;
  logic               vs;
  logic               line_start;
  logic               frame_start;

  modport master (output x, y, blank, hs, vs, line_start, frame_start);
  modport slave  (input  x, y, blank, hs, vs, line_start, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping counter plus its VISIBLE/FRONT/SYNC/BACK phase FSM.
// Decodes are of the next-state values so the parent can register them in
// step with the coordinate they describe.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned FRONT   = H_FRONT_DEF,
  parameter int unsigned SYNC    = H_SYNC_DEF,
  parameter int unsigned BACK    = H_BACK_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  output coord_t cnt_nxt_c_o,
  output logic   wrap_c_o,
  output logic   sync_nxt_c_o,
  output logic   visible_nxt_c_o
);

  localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

  // Last count of each phase; the phase advances on the edge leaving it.
  localparam coord_t VIS_END   = COORD_W'(VISIBLE - 1);
  localparam coord_t FRONT_END = COORD_W'(VISIBLE + FRONT - 1);
  localparam coord_t SYNC_END  = COORD_W'(VISIBLE + FRONT + SYNC - 1);
  localparam coord_t TOT_END   = COORD_W'(TOTAL - 1);

  coord_t cnt_q;
  coord_t cnt_d;
  phase_e phase_q;
  phase_e phase_d;

  // State register: reset parks the axis on its last count so the first
  // enabled edge after release lands on 0 / VISIBLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= TOT_END;
      phase_q <= PH_BACK;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: count and phase advance together when enabled.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (en_i) begin
      cnt_d = (cnt_q == TOT_END) ? '0 : cnt_q + COORD_W'(1);
      case (phase_q)
        PH_VISIBLE: if (cnt_q == VIS_END)   phase_d = PH_FRONT;
        PH_FRONT:   if (cnt_q == FRONT_END) phase_d = PH_SYNC;
        PH_SYNC:    if (cnt_q == SYNC_END)  phase_d = PH_BACK;
        PH_BACK:    if (cnt_q == TOT_END)   phase_d = PH_VISIBLE;
        default:    phase_d = PH_BACK;
      endcase
    end
  end

  // Output decode of the upcoming state.
  always_comb begin
    cnt_nxt_c_o     = cnt_d;
    wrap_c_o        = en_i && (cnt_q == TOT_END);
    sync_nxt_c_o    = (phase_d == PH_SYNC);
    visible_nxt_c_o = (phase_d == PH_VISIBLE);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters with
// fully registered coordinate, sync, blank and start-pulse outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Output values held while in reset: last pixel of the frame, syncs idle.
  localparam raster_t RASTER_RST = '{
    x:           COORD_W'(H_TOTAL - 1),
    y:           COORD_W'(V_TOTAL - 1),
    blank:       1'b0,
    hs_n:        1'b1,
    vs_n:        1'b1,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  coord_t  h_cnt_nxt_c;
  coord_t  v_cnt_nxt_c;
  logic    h_wrap_c;
  logic    v_wrap_c;
  logic    h_sync_nxt_c;
  logic    v_sync_nxt_c;
  logic    h_vis_nxt_c;
  logic    v_vis_nxt_c;
  raster_t raster_q;
  raster_t raster_d;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk             (vga_clk),
    .rst_n           (reset_n),
    .en_i            (1'b1),
    .cnt_nxt_c_o     (h_cnt_nxt_c),
    .wrap_c_o        (h_wrap_c),
    .sync_nxt_c_o    (h_sync_nxt_c),
    .visible_nxt_c_o (h_vis_nxt_c)
  );

  // Vertical axis steps once per line, on the horizontal wrap edge.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk             (vga_clk),
    .rst_n           (reset_n),
    .en_i            (h_wrap_c),
    .cnt_nxt_c_o     (v_cnt_nxt_c),
    .wrap_c_o        (v_wrap_c),
    .sync_nxt_c_o    (v_sync_nxt_c),
    .visible_nxt_c_o (v_vis_nxt_c)
  );

  // Raster decode from next-state counters so every output lines up with its coordinate.
  always_comb begin
    raster_d             = raster_q;
    raster_d.x           = h_cnt_nxt_c;
    raster_d.y           = v_cnt_nxt_c;
    raster_d.blank       = h_vis_nxt_c && v_vis_nxt_c;
    raster_d.hs_n        = !h_sync_nxt_c;
    raster_d.vs_n        = !v_sync_nxt_c;
    raster_d.line_start  = h_wrap_c;
    raster_d.frame_start = h_wrap_c && v_wrap_c;
  end

  // Output register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      raster_q <= RASTER_RST;
    end else begin
      raster_q <= raster_d;
    end
  end

  assign DrawX       = raster_q.x;
  assign DrawY       = raster_q.y;
  assign blank       = raster_q.blank;
  assign hs          = raster_q.hs_n;
  assign vs          = raster_q.vs_n;
  assign line_start  = raster_q.line_start;
  assign frame_start = raster_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-geometry
// instance, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int DH_V = 640, DH_F = 16, DH_S = 96, DH_B = 48;
  localparam int DV_V = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
  localparam int SH_V = 8,   SH_F = 2,  SH_S = 3,  SH_B = 1;
  localparam int SV_V = 6,   SV_F = 2,  SV_S = 2,  SV_B = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } ras_t;

  logic vga_clk = 1'b0;
  logic rst_def;
  logic rst_sml;

  int   n_edge [2];
  ras_t obs    [2];
  ras_t prev   [2];
  int   checks, passes, fails;

  int st_cyc [2], st_blank [2], st_ls [2], st_fs [2];
  int st_hslow [2], st_vslow [2], st_hsfall [2], st_hsmin [2], st_hsmax [2];

  vga_timing_if vif ();
  vga_timing_if sif ();

  vga_timing_gen u_def (
    .vga_clk     (vga_clk),
    .reset_n     (rst_def),
    .DrawX       (vif.x),
    .DrawY       (vif.y),
    .blank       (vif.blank),
    .hs          (vif.hs),
    .vs          (vif.vs),
    .line_start  (vif.line_start),
    .frame_start (vif.frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE (SH_V), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
    .V_VISIBLE (SV_V), .V_FRONT (SV_F), .V_SYNC (SV_S), .V_BACK (SV_B)
  ) u_sml (
    .vga_clk     (vga_clk),
    .reset_n     (rst_sml),
    .DrawX       (sif.x),
    .DrawY       (sif.y),
    .blank       (sif.blank),
    .hs          (sif.hs),
    .vs          (sif.vs),
    .line_start  (sif.line_start),
    .frame_start (sif.frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic string nm(input int d);
    return (d == 0) ? "def" : "sml";
  endfunction

  // Expected raster after n clock edges since reset release (n = 0: in reset).
  function automatic ras_t model(input int d, input int n);
    int hv, hf, hsy, hb, vv, vf, vsy, vb, ht, vt, k, x, y;
    ras_t r;
    if (d == 0) begin
      hv = DH_V; hf = DH_F; hsy = DH_S; hb = DH_B;
      vv = DV_V; vf = DV_F; vsy = DV_S; vb = DV_B;
    end else begin
      hv = SH_V; hf = SH_F; hsy = SH_S; hb = SH_B;
      vv = SV_V; vf = SV_F; vsy = SV_S; vb = SV_B;
    end
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    if (n == 0) begin
      x = ht - 1;
      y = vt - 1;
    end else begin
      k = n - 1;
      x = k % ht;
      y = (k / ht) % vt;
    end
    r.x     = 10'(x);
    r.y     = 10'(y);
    r.blank = (n != 0) && (x < hv) && (y < vv);
    r.hs    = !((n != 0) && (x >= hv + hf) && (x < hv + hf + hsy));
    r.vs    = !((n != 0) && (y >= vv + vf) && (y < vv + vf + vsy));
    r.ls    = (n != 0) && (x == 0);
    r.fs    = (n != 0) && (x == 0) && (y == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic clear_stats(input int d);
    st_cyc[d] = 0; st_blank[d] = 0; st_ls[d] = 0; st_fs[d] = 0;
    st_hslow[d] = 0; st_vslow[d] = 0; st_hsfall[d] = 0;
    st_hsmin[d] = 1023; st_hsmax[d] = 0;
  endtask

  // Sample both DUTs, compare against the model, accumulate window statistics.
  task automatic sample_and_check();
    ras_t e;
    for (int d = 0; d < 2; d++) begin
      prev[d] = obs[d];
      if (d == 0)
        obs[d] = {vif.x, vif.y, vif.blank, vif.hs, vif.vs, vif.line_start, vif.frame_start};
      else
        obs[d] = {sif.x, sif.y, sif.blank, sif.hs, sif.vs, sif.line_start, sif.frame_start};
      e = model(d, n_edge[d]);
      check($sformatf("%s.DrawX@%0d", nm(d), n_edge[d]), 32'(obs[d].x), 32'(e.x));
      check($sformatf("%s.DrawY@%0d", nm(d), n_edge[d]), 32'(obs[d].y), 32'(e.y));
      check($sformatf("%s.blank@%0d", nm(d), n_edge[d]), 32'(obs[d].blank), 32'(e.blank));
      check($sformatf("%s.hs@%0d", nm(d), n_edge[d]), 32'(obs[d].hs), 32'(e.hs));
      check($sformatf("%s.vs@%0d", nm(d), n_edge[d]), 32'(obs[d].vs), 32'(e.vs));
      check($sformatf("%s.line_start@%0d", nm(d), n_edge[d]), 32'(obs[d].ls), 32'(e.ls));
      check($sformatf("%s.frame_start@%0d", nm(d), n_edge[d]), 32'(obs[d].fs), 32'(e.fs));
      st_cyc[d]++;
      if (obs[d].blank === 1'b1) st_blank[d]++;
      if (obs[d].ls === 1'b1) st_ls[d]++;
      if (obs[d].fs === 1'b1) st_fs[d]++;
      if (obs[d].vs === 1'b0) st_vslow[d]++;
      if (obs[d].hs === 1'b0) begin
        st_hslow[d]++;
        if (int'(obs[d].x) < st_hsmin[d]) st_hsmin[d] = int'(obs[d].x);
        if (int'(obs[d].x) > st_hsmax[d]) st_hsmax[d] = int'(obs[d].x);
        if (prev[d].hs === 1'b1) st_hsfall[d]++;
      end
    end
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge vga_clk);
      if (rst_def) n_edge[0]++;
      if (rst_sml) n_edge[1]++;
      #1;
      sample_and_check();
    end
  endtask

  // Step until DUT d shows (x, y); y < 0 matches any line. Bounded.
  task automatic wait_xy(input int d, input int x, input int y, input int bound, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      step(1);
      hit = (int'(obs[d].x) == x) && ((y < 0) || (int'(obs[d].y) == y));
    end
    check({tag, ".reached"}, 32'(hit), 32'd1);
  endtask

  // Assert reset between clock edges and check outputs react without an edge.
  task automatic async_reset(input int d);
    #2;
    if (d == 0) rst_def = 1'b0; else rst_sml = 1'b0;
    n_edge[d] = 0;
    #1;
    sample_and_check();
    check($sformatf("%s.rst_hs_now", nm(d)), 32'(obs[d].hs), 32'd1);
    check($sformatf("%s.rst_vs_now", nm(d)), 32'(obs[d].vs), 32'd1);
  endtask

  task automatic do_release(input int d);
    if (d == 0) rst_def = 1'b1; else rst_sml = 1'b1;
  endtask

  initial begin
    int len, d;
    checks = 0; passes = 0; fails = 0;
    n_edge[0] = 0; n_edge[1] = 0;
    obs[0] = '0; obs[1] = '0;
    clear_stats(0); clear_stats(1);
    rst_def = 1'b1;
    rst_sml = 1'b1;

    // Reset asserted before any clock edge.
    #2;
    rst_def = 1'b0;
    rst_sml = 1'b0;
    #1;
    sample_and_check();
    check("def.rst_DrawX", 32'(obs[0].x), 32'd799);
    check("def.rst_DrawY", 32'(obs[0].y), 32'd524);
    check("def.rst_blank", 32'(obs[0].blank), 32'd0);
    check("def.rst_hs", 32'(obs[0].hs), 32'd1);
    check("def.rst_vs", 32'(obs[0].vs), 32'd1);
    check("sml.rst_DrawX", 32'(obs[1].x), 32'd13);
    check("sml.rst_DrawY", 32'(obs[1].y), 32'd10);

    // Held across clock edges.
    step(3);
    check("def.rst_held_DrawX", 32'(obs[0].x), 32'd799);
    check("def.rst_held_DrawY", 32'(obs[0].y), 32'd524);

    // First edge after release lands on the top of a frame.
    do_release(0);
    do_release(1);
    step(1);
    check("def.first_DrawX", 32'(obs[0].x), 32'd0);
    check("def.first_DrawY", 32'(obs[0].y), 32'd0);
    check("def.first_blank", 32'(obs[0].blank), 32'd1);
    check("def.first_line_start", 32'(obs[0].ls), 32'd1);
    check("def.first_frame_start", 32'(obs[0].fs), 32'd1);
    check("sml.first_frame_start", 32'(obs[1].fs), 32'd1);

    // One full default line, window = x 1..799 then x 0 of line 1.
    clear_stats(0);
    wait_xy(0, 0, 1, 900, "def_line");
    check("def.line_cycles", 32'(st_cyc[0]), 32'd800);
    check("def.line_hs_low", 32'(st_hslow[0]), 32'd96);
    check("def.line_hs_pulses", 32'(st_hsfall[0]), 32'd1);
    check("def.line_hs_first_x", 32'(st_hsmin[0]), 32'd656);
    check("def.line_hs_last_x", 32'(st_hsmax[0]), 32'd751);
    check("def.line_blank_high", 32'(st_blank[0]), 32'd640);
    check("def.line_starts", 32'(st_ls[0]), 32'd1);
    check("def.wrap_prev_DrawX", 32'(prev[0].x), 32'd799);
    check("def.wrap_prev_DrawY", 32'(prev[0].y), 32'd0);
    check("def.wrap_DrawX", 32'(obs[0].x), 32'd0);
    check("def.wrap_DrawY", 32'(obs[0].y), 32'd1);

    // One full frame of the small geometry (14 x 11).
    wait_xy(1, 0, 0, 200, "sml_frame_a");
    clear_stats(1);
    wait_xy(1, 0, 0, 200, "sml_frame_b");
    check("sml.frame_cycles", 32'(st_cyc[1]), 32'd154);
    check("sml.frame_blank_high", 32'(st_blank[1]), 32'd48);
    check("sml.frame_line_starts", 32'(st_ls[1]), 32'd11);
    check("sml.frame_starts", 32'(st_fs[1]), 32'd1);
    check("sml.frame_vs_low", 32'(st_vslow[1]), 32'd28);
    check("sml.frame_hs_low", 32'(st_hslow[1]), 32'd33);
    check("sml.frame_hs_pulses", 32'(st_hsfall[1]), 32'd11);
    check("sml.hs_first_x", 32'(st_hsmin[1]), 32'd10);
    check("sml.hs_last_x", 32'(st_hsmax[1]), 32'd12);
    check("sml.fwrap_prev_DrawX", 32'(prev[1].x), 32'd13);
    check("sml.fwrap_prev_DrawY", 32'(prev[1].y), 32'd10);
    check("sml.fwrap_DrawX", 32'(obs[1].x), 32'd0);
    check("sml.fwrap_DrawY", 32'(obs[1].y), 32'd0);

    // Reset inside both sync pulses of the small instance.
    wait_xy(1, 11, 9, 200, "sml_sync_point");
    check("sml.in_sync_hs", 32'(obs[1].hs), 32'd0);
    check("sml.in_sync_vs", 32'(obs[1].vs), 32'd0);
    async_reset(1);
    step(2);
    do_release(1);
    step(1);
    check("sml.restart_frame_start", 32'(obs[1].fs), 32'd1);
    check("sml.restart_hs", 32'(obs[1].hs), 32'd1);

    // Reset inside the horizontal sync pulse of the default instance.
    wait_xy(0, 700, -1, 900, "def_hs_point");
    check("def.in_sync_hs", 32'(obs[0].hs), 32'd0);
    async_reset(0);
    do_release(0);
    step(1);
    check("def.restart_frame_start", 32'(obs[0].fs), 32'd1);
    check("def.restart_DrawX", 32'(obs[0].x), 32'd0);

    // Random run lengths with random mid-frame resets on either instance.
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(700, 1));
      step(len);
      d = int'($urandom_range(1, 0));
      async_reset(d);
      step(int'($urandom_range(3, 0)));
      do_release(d);
      step(1);
      check($sformatf("%s.rand_restart_%0d", nm(d), r), 32'(obs[d].fs), 32'd1);
    end
    step(50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
